// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state enum, default timing constants and width helper for the button conditioner
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_CYCLES   = 50_000_000;

  // One counter width serves both the debounce and repeat timers.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with synchronous active-high reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  // Two back-to-back flops give metastability a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/btn_load_conditioner.sv
// rtl/btn_load_conditioner.sv - debounced button level and one-cycle load strobe; BTN_AUTOREPEAT_EN adds auto-repeat
module btn_load_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic a_pulse,
  output logic btn_level
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  logic       sync;
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       a_pulse_q, a_pulse_d;
  logic       btn_level_q, btn_level_d;
`ifdef BTN_AUTOREPEAT_EN
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

  // Debounce FSM next-state: a press or release is accepted only after
  // DEBOUNCE_CYCLES stable samples; the strobe is raised only on acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_pulse_d   = 1'b0;
    btn_level_d = btn_level_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          a_pulse_d   = 1'b1;
          btn_level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          a_pulse_d = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_pulse_q   <= 1'b0;
      btn_level_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_pulse_q   <= a_pulse_d;
      btn_level_q <= btn_level_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign a_pulse   = a_pulse_q;
  assign btn_level = btn_level_q;

endmodule
